// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter
// Arbitrates the single DCache port between the committing store at the
// store-queue head and the load-queue entries. It also runs one outstanding
// load miss to memory. Hits are still serviced while that miss is in flight.
//
// Ports
//   clock, reset         : clock and asynchronous active-high reset
//   except               : squash all loads (cancels or drains the miss)
//   st_req/addr/data/size: committed store request; st_gnt is the write grant
//   ld_req/addr/size     : per-entry load requests; rd_gnt is the one-hot grant
//   dc_*                 : DCache port strobes and address/data/size, plus
//                          the same-cycle hit and read data coming back
//   dc_feedback, dc_data : one-hot hit completion and hit data (combinational)
//   mem_req_*            : miss request to memory (valid/ready handshake)
//   mem_resp_*           : fill response from memory
//   mem_feedback/data    : registered one-cycle fill completion to the LQ
//   busy                 : miss sequencer is not idle

// Per-entry slice: eligibility, grant/feedback decode and the AND terms of
// the address/size mux. The top level OR-reduces the mux terms.
module dcache_arb_lane (
    input  logic        req,
    input  logic        mask,
    input  logic        kill,
    input  logic        sel,
    input  logic        hit,
    input  logic [15:0] addr,
    input  logic [1:0]  size,
    output logic        elig,
    output logic        gnt,
    output logic        fb,
    output logic [15:0] addr_term,
    output logic [1:0]  size_term
);
    assign elig      = req & ~mask & ~kill;
    assign gnt       = sel;
    assign fb        = sel & hit;
    assign addr_term = sel ? addr : '0;
    assign size_term = sel ? size : '0;
endmodule

module dcache_port_arbiter #(
    parameter int LSQSZ        = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   except,
    input  logic                   st_req,
    input  logic [15:0]            st_addr,
    input  logic [31:0]            st_data,
    input  logic [1:0]             st_size,
    output logic                   st_gnt,
    input  logic [LSQSZ-1:0]       ld_req,
    input  logic [LSQSZ-1:0][15:0] ld_addr,
    input  logic [LSQSZ-1:0][1:0]  ld_size,
    output logic [LSQSZ-1:0]       rd_gnt,
    output logic                   dc_wr_en,
    output logic                   dc_rd_en,
    output logic [15:0]            dc_addr,
    output logic [31:0]            dc_wr_data,
    output logic [1:0]             dc_size,
    input  logic                   dc_hit,
    input  logic [31:0]            dc_rd_data,
    output logic [LSQSZ-1:0]       dc_feedback,
    output logic [31:0]            dc_data,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [15:0]            mem_req_addr,
    output logic [1:0]             mem_req_size,
    input  logic                   mem_resp_valid,
    input  logic [31:0]            mem_resp_data,
    output logic [LSQSZ-1:0]       mem_feedback,
    output logic [31:0]            mem_data,
    output logic                   busy
);
    localparam int IW = (LSQSZ > 1) ? $clog2(LSQSZ) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;

    state_t            state, state_n;
    logic [IW-1:0]     rr_ptr;
    logic [SW-1:0]     starve_cnt;
    logic [IW-1:0]     miss_idx;
    logic [15:0]       miss_addr;
    logic [1:0]        miss_size;

    logic [LSQSZ-1:0]       mask;
    logic [LSQSZ-1:0]       elig;
    logic [LSQSZ-1:0]       lane_sel;
    logic [LSQSZ-1:0][15:0] addr_terms;
    logic [LSQSZ-1:0][1:0]  size_terms;
    logic                   any_elig;
    logic                   ld_found;
    logic [IW-1:0]          ld_sel;
    logic                   store_win;
    logic                   load_win;
    logic [15:0]            ld_addr_mux;
    logic [1:0]             ld_size_mux;
    logic                   capture;
    logic                   fill;
    logic [LSQSZ-1:0]       miss_onehot;

    assign miss_onehot = LSQSZ'(1) << miss_idx;
    // The entry whose miss is in flight must not be re-granted until its fill.
    assign mask        = (state != S_IDLE) ? miss_onehot : '0;
    assign any_elig    = |elig;

    // Round-robin pick: first eligible entry at or after rr_ptr.
    always_comb begin
        ld_found = 1'b0;
        ld_sel   = '0;
        for (int k = 0; k < LSQSZ; k++) begin
            if (!ld_found && elig[(int'(rr_ptr) + k) % LSQSZ]) begin
                ld_found = 1'b1;
                ld_sel   = IW'((int'(rr_ptr) + k) % LSQSZ);
            end
        end
    end

    // The store normally wins; a waiting load overrides it only once the
    // store has won STARVE_LIMIT times in a row against it.
    assign store_win = st_req && (!any_elig || (starve_cnt < SW'(STARVE_LIMIT)));
    assign load_win  = ld_found && !store_win;

    for (genvar i = 0; i < LSQSZ; i++) begin : g_lane
        assign lane_sel[i] = load_win && (ld_sel == IW'(i));
        dcache_arb_lane u_lane (
            .req       (ld_req[i]),
            .mask      (mask[i]),
            .kill      (except),
            .sel       (lane_sel[i]),
            .hit       (dc_hit),
            .addr      (ld_addr[i]),
            .size      (ld_size[i]),
            .elig      (elig[i]),
            .gnt       (rd_gnt[i]),
            .fb        (dc_feedback[i]),
            .addr_term (addr_terms[i]),
            .size_term (size_terms[i])
        );
    end

    always_comb begin
        ld_addr_mux = '0;
        ld_size_mux = '0;
        for (int i = 0; i < LSQSZ; i++) begin
            ld_addr_mux = ld_addr_mux | addr_terms[i];
            ld_size_mux = ld_size_mux | size_terms[i];
        end
    end

    assign st_gnt     = store_win;
    assign dc_wr_en   = store_win;
    assign dc_rd_en   = load_win;
    assign dc_addr    = store_win ? st_addr : ld_addr_mux;
    assign dc_size    = store_win ? st_size : ld_size_mux;
    assign dc_wr_data = store_win ? st_data : '0;
    assign dc_data    = (load_win && dc_hit) ? dc_rd_data : '0;

    assign busy         = (state != S_IDLE);
    assign mem_req_addr = mem_req_valid ? miss_addr : '0;
    assign mem_req_size = mem_req_valid ? miss_size : '0;

    // Miss sequencer: state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    // Miss sequencer: next state and request strobe.
    always_comb begin
        state_n       = state;
        capture       = 1'b0;
        fill          = 1'b0;
        mem_req_valid = 1'b0;
        case (state)
            S_IDLE: begin
                // A miss while busy is simply dropped; the entry retries.
                if (load_win && !dc_hit) begin
                    capture = 1'b1;
                    state_n = S_REQ;
                end
            end
            S_REQ: begin
                if (except) begin
                    state_n = S_IDLE;
                end else begin
                    mem_req_valid = 1'b1;
                    if (mem_req_ready) state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                // A squash that coincides with the response drops the data.
                if (except) begin
                    state_n = mem_resp_valid ? S_IDLE : S_DRAIN;
                end else if (mem_resp_valid) begin
                    fill    = 1'b1;
                    state_n = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (mem_resp_valid) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr       <= '0;
            starve_cnt   <= '0;
            miss_idx     <= '0;
            miss_addr    <= '0;
            miss_size    <= '0;
            mem_feedback <= '0;
            mem_data     <= '0;
        end else begin
            if (load_win)
                rr_ptr <= (ld_sel == IW'(LSQSZ - 1)) ? '0 : ld_sel + 1'b1;

            if (load_win || !any_elig) starve_cnt <= '0;
            else if (store_win)        starve_cnt <= starve_cnt + 1'b1;

            if (capture) begin
                miss_idx  <= ld_sel;
                miss_addr <= ld_addr_mux;
                miss_size <= ld_size_mux;
            end

            mem_feedback <= fill ? miss_onehot : '0;
            if (fill) mem_data <= mem_resp_data;
        end
    end
endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed bench for dcache_port_arbiter. Stimulus pushes the expected
// output tuple for each cycle in which the arbiter should produce something.
// A negedge monitor pops and compares whenever the DUT shows any output.
module tb_dcache_port_arbiter;
    logic             clock, reset, except;
    logic             st_req;
    logic [15:0]      st_addr;
    logic [31:0]      st_data;
    logic [1:0]       st_size;
    logic             st_gnt;
    logic [7:0]       ld_req;
    logic [7:0][15:0] ld_addr;
    logic [7:0][1:0]  ld_size;
    logic [7:0]       rd_gnt;
    logic             dc_wr_en, dc_rd_en;
    logic [15:0]      dc_addr;
    logic [31:0]      dc_wr_data;
    logic [1:0]       dc_size;
    logic             dc_hit;
    logic [31:0]      dc_rd_data;
    logic [7:0]       dc_feedback;
    logic [31:0]      dc_data;
    logic             mem_req_valid, mem_req_ready;
    logic [15:0]      mem_req_addr;
    logic [1:0]       mem_req_size;
    logic             mem_resp_valid;
    logic [31:0]      mem_resp_data;
    logic [7:0]       mem_feedback;
    logic [31:0]      mem_data;
    logic             busy;

    dcache_port_arbiter #(.LSQSZ(8), .STARVE_LIMIT(4)) dut (
        .clock(clock), .reset(reset), .except(except),
        .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
        .st_gnt(st_gnt), .ld_req(ld_req), .ld_addr(ld_addr), .ld_size(ld_size),
        .rd_gnt(rd_gnt), .dc_wr_en(dc_wr_en), .dc_rd_en(dc_rd_en), .dc_addr(dc_addr),
        .dc_wr_data(dc_wr_data), .dc_size(dc_size), .dc_hit(dc_hit),
        .dc_rd_data(dc_rd_data), .dc_feedback(dc_feedback), .dc_data(dc_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_size(mem_req_size),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .mem_feedback(mem_feedback), .mem_data(mem_data), .busy(busy)
    );

    typedef struct {
        string       nm;
        logic        sg;
        logic [7:0]  rg;
        logic [7:0]  fb;
        logic [31:0] dd;
        logic [15:0] da;
        logic [1:0]  dz;
        logic        mrv;
        logic [15:0] ma;
        logic [7:0]  mf;
        logic [31:0] md;
        logic        bz;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    logic ok;

    localparam logic [31:0] ST_DATA = 32'hCAFE0001;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic st, input logic [7:0] ld, input logic hit,
                         input logic [31:0] rd, input logic rdy, input logic rv,
                         input logic [31:0] rdm, input logic exc);
        st_req = st; ld_req = ld; dc_hit = hit; dc_rd_data = rd;
        mem_req_ready = rdy; mem_resp_valid = rv; mem_resp_data = rdm; except = exc;
    endtask

    task automatic expect_out(input string nm, input logic sg, input logic [7:0] rg,
                              input logic [7:0] fb, input logic [31:0] dd,
                              input logic [15:0] da, input logic [1:0] dz,
                              input logic mrv, input logic [15:0] ma,
                              input logic [7:0] mf, input logic [31:0] md,
                              input logic bz);
        exp_t x;
        x.nm = nm; x.sg = sg; x.rg = rg; x.fb = fb; x.dd = dd; x.da = da; x.dz = dz;
        x.mrv = mrv; x.ma = ma; x.mf = mf; x.md = md; x.bz = bz;
        sb.push_back(x);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, want);
        end
    endtask

    // Monitor: any visible DUT activity must match the next expected tuple.
    always @(negedge clock) begin
        if (!reset && (st_gnt || rd_gnt != 0 || dc_feedback != 0 ||
                       mem_feedback != 0 || mem_req_valid)) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output st=%0b rd=%h fb=%h mf=%h mrv=%0b",
                         st_gnt, rd_gnt, dc_feedback, mem_feedback, mem_req_valid);
            end else begin
                e = sb.pop_front();
                ok = (st_gnt === e.sg) && (dc_wr_en === e.sg) &&
                     (dc_wr_data === (e.sg ? ST_DATA : 32'h0)) &&
                     (rd_gnt === e.rg) && (dc_rd_en === (e.rg != 0)) &&
                     (dc_feedback === e.fb) && (dc_data === e.dd) &&
                     (dc_addr === e.da) && (dc_size === e.dz) &&
                     (mem_req_valid === e.mrv) && (mem_req_addr === e.ma) &&
                     (mem_feedback === e.mf) && (busy === e.bz) &&
                     ((e.mf == 0) || (mem_data === e.md));
                if (!ok) begin
                    errors++;
                    $display("FAIL %s got st=%0b rd=%h fb=%h dd=%h da=%h dz=%0d mrv=%0b ma=%h mf=%h md=%h bz=%0b exp st=%0b rd=%h fb=%h dd=%h da=%h dz=%0d mrv=%0b ma=%h mf=%h md=%h bz=%0b",
                             e.nm, st_gnt, rd_gnt, dc_feedback, dc_data, dc_addr, dc_size,
                             mem_req_valid, mem_req_addr, mem_feedback, mem_data, busy,
                             e.sg, e.rg, e.fb, e.dd, e.da, e.dz, e.mrv, e.ma, e.mf, e.md, e.bz);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        st_addr = 16'h2000; st_data = ST_DATA; st_size = 2'd2;
        for (int i = 0; i < 8; i++) begin
            ld_addr[i] = 16'h1000 + 16'(i) * 16'h10;
            ld_size[i] = 2'(i);
        end
        drive(0, 8'h00, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        chk("rst_st_gnt", 32'(st_gnt), 0);
        chk("rst_rd_gnt", 32'(rd_gnt), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_mem_req_valid", 32'(mem_req_valid), 0);
        chk("rst_mem_feedback", 32'(mem_feedback), 0);
        chk("rst_mem_data", mem_data, 0);
        chk("rst_dc_addr", 32'(dc_addr), 0);
        reset = 1'b0;
        tick();

        // Round-robin hits
        drive(0, 8'h05, 1, 32'h11111111, 0, 0, 0, 0);
        expect_out("hit0", 0, 8'h01, 8'h01, 32'h11111111, 16'h1000, 2'd0, 0, 0, 0, 0, 0); tick();
        drive(0, 8'h04, 1, 32'h22222222, 0, 0, 0, 0);
        expect_out("hit2", 0, 8'h04, 8'h04, 32'h22222222, 16'h1020, 2'd2, 0, 0, 0, 0, 0); tick();

        // Starvation: four store wins, then load 3, then counter cleared
        for (int c = 0; c < 4; c++) begin
            drive(1, 8'h08, 1, 32'h33333333, 0, 0, 0, 0);
            expect_out("st_win", 1, 8'h00, 8'h00, 32'h0, 16'h2000, 2'd2, 0, 0, 0, 0, 0); tick();
        end
        drive(1, 8'h08, 1, 32'h33333333, 0, 0, 0, 0);
        expect_out("starve_ld", 0, 8'h08, 8'h08, 32'h33333333, 16'h1030, 2'd3, 0, 0, 0, 0, 0); tick();
        drive(1, 8'h08, 1, 32'h33333333, 0, 0, 0, 0);
        expect_out("st_after_clr", 1, 8'h00, 8'h00, 32'h0, 16'h2000, 2'd2, 0, 0, 0, 0, 0); tick();
        drive(0, 8'h00, 0, 0, 0, 0, 0, 0); tick();

        // Miss on load 2 with hits and a retried miss under it
        drive(0, 8'h04, 0, 0, 0, 0, 0, 0);
        expect_out("miss2", 0, 8'h04, 8'h00, 32'h0, 16'h1020, 2'd2, 0, 0, 0, 0, 0); tick();
        drive(0, 8'h04, 0, 0, 1, 0, 0, 0);
        expect_out("req2", 0, 8'h00, 8'h00, 32'h0, 16'h0, 2'd0, 1, 16'h1020, 0, 0, 1); tick();
        drive(0, 8'h24, 1, 32'h55555555, 0, 0, 0, 0);
        expect_out("hit5_wait", 0, 8'h20, 8'h20, 32'h55555555, 16'h1050, 2'd1, 0, 0, 0, 0, 1); tick();
        drive(0, 8'h44, 0, 0, 0, 0, 0, 0);
        expect_out("miss6_wait", 0, 8'h40, 8'h00, 32'h0, 16'h1060, 2'd2, 0, 0, 0, 0, 1); tick();
        drive(0, 8'h44, 1, 32'h66666666, 0, 1, 32'hDEADBEEF, 0);
        expect_out("retry6", 0, 8'h40, 8'h40, 32'h66666666, 16'h1060, 2'd2, 0, 0, 0, 0, 1); tick();
        drive(0, 8'h00, 0, 0, 0, 0, 0, 0);
        expect_out("fill2", 0, 8'h00, 8'h00, 32'h0, 16'h0, 2'd0, 0, 0, 8'h04, 32'hDEADBEEF, 0); tick();

        // Squash in WAIT -> DRAIN, late response discarded, store still granted
        drive(0, 8'h02, 0, 0, 0, 0, 0, 0);
        expect_out("miss1", 0, 8'h02, 8'h00, 32'h0, 16'h1010, 2'd1, 0, 0, 0, 0, 0); tick();
        drive(0, 8'h02, 0, 0, 1, 0, 0, 0);
        expect_out("req1", 0, 8'h00, 8'h00, 32'h0, 16'h0, 2'd0, 1, 16'h1010, 0, 0, 1); tick();
        drive(1, 8'h02, 0, 0, 0, 0, 0, 1);
        expect_out("st_exc", 1, 8'h00, 8'h00, 32'h0, 16'h2000, 2'd2, 0, 0, 0, 0, 1); tick();
        drive(0, 8'h00, 0, 0, 0, 0, 0, 0);
        @(negedge clock); chk("drain_busy", 32'(busy), 1); tick();
        tick();
        drive(0, 8'h00, 0, 0, 0, 1, 32'hBAD0BAD0, 0); tick();
        drive(0, 8'h00, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        chk("drain_idle", 32'(busy), 0);
        chk("drain_no_fb", 32'(mem_feedback), 0);
        tick();

        // Reset while in REQ
        drive(0, 8'h20, 0, 0, 0, 0, 0, 0);
        expect_out("miss5", 0, 8'h20, 8'h00, 32'h0, 16'h1050, 2'd1, 0, 0, 0, 0, 0); tick();
        expect_out("req5", 0, 8'h00, 8'h00, 32'h0, 16'h0, 2'd0, 1, 16'h1050, 0, 0, 1);
        @(negedge clock); #1;
        reset = 1'b1;
        #1;
        chk("rst_req_valid", 32'(mem_req_valid), 0);
        chk("rst_req_busy", 32'(busy), 0);
        drive(0, 8'h00, 0, 0, 0, 0, 0, 0);
        tick();
        reset = 1'b0;

        // rr_ptr back at 0, then wrap from entry 7
        drive(0, 8'hFF, 1, 32'h77777777, 0, 0, 0, 0);
        expect_out("rst_rr", 0, 8'h01, 8'h01, 32'h77777777, 16'h1000, 2'd0, 0, 0, 0, 0, 0); tick();
        drive(0, 8'h80, 1, 32'h88888888, 0, 0, 0, 0);
        expect_out("hit7", 0, 8'h80, 8'h80, 32'h88888888, 16'h1070, 2'd3, 0, 0, 0, 0, 0); tick();
        drive(0, 8'h81, 1, 32'h99999999, 0, 0, 0, 0);
        expect_out("wrap", 0, 8'h01, 8'h01, 32'h99999999, 16'h1000, 2'd0, 0, 0, 0, 0, 0); tick();
        drive(0, 8'h00, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        chk("sb_drained", 32'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
